address_demapper: RTL and testbench

ADDRESS_DEMAPPER -- requirements
Module: address_demapper

---
 rtl/address_demapper.sv | 169 ++++++++++++++++
 tb/tb_address_demapper.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/address_demapper.sv
// Turns an SDRAM (rank, bank, row, column, length) command into a burst of
// NASTI byte addresses, one per beat, with the column wrapping inside the row.
module address_demapper #(
  parameter int C_NASTI_ADDR_WIDTH = 40,
  parameter int C_CS_WIDTH         = 1,
  parameter int C_DQ_WIDTH         = 64,
  parameter int C_ROW_WIDTH        = 16,
  parameter int C_BANK_WIDTH       = 3,
  parameter int C_LEN_WIDTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    r_width,
  input  logic [1:0]                    c_width,
  input  logic                          bor,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [C_CS_WIDTH-1:0]         in_rank,
  input  logic [C_BANK_WIDTH-1:0]       in_bank,
  input  logic [C_ROW_WIDTH-1:0]        in_row,
  input  logic [11:0]                   in_column,
  input  logic [C_LEN_WIDTH-1:0]        in_len,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_NASTI_ADDR_WIDTH-1:0] out_addr,
  output logic                          out_last
);

  localparam int AW          = C_NASTI_ADDR_WIDTH;
  localparam int OFFSET_BITS = $clog2(C_DQ_WIDTH / 8);

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;

  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = C_LEN_WIDTH'(1);

  if (OFFSET_BITS + 12 + 16 + C_BANK_WIDTH + C_CS_WIDTH > C_NASTI_ADDR_WIDTH ||
      C_ROW_WIDTH < 16) begin : g_param_check
    $fatal(1, "address_demapper: address width too small or row width below 16");
  end

  // Geometry encodings: r11..r15 = 0..4 select 12..16 row bits,
  // c9/c10/c11 = 0/1/2 select 10/11/12 column bits.
  function automatic int row_bits(input logic [2:0] rw);
    case (rw)
      3'd0:    row_bits = 12;
      3'd1:    row_bits = 13;
      3'd2:    row_bits = 14;
      3'd3:    row_bits = 15;
      3'd4:    row_bits = 16;
      default: row_bits = 16;
    endcase
  endfunction

  function automatic int col_bits(input logic [1:0] cw);
    case (cw)
      2'd0:    col_bits = 10;
      2'd1:    col_bits = 11;
      2'd2:    col_bits = 12;
      default: col_bits = 12;
    endcase
  endfunction

  function automatic logic [11:0] col_mask(input logic [1:0] cw);
    col_mask = 12'hFFF >> (12 - col_bits(cw));
  endfunction

  function automatic logic [AW-1:0] pack_addr(
    input logic [C_CS_WIDTH-1:0]   rank,
    input logic [C_BANK_WIDTH-1:0] bank,
    input logic [C_ROW_WIDTH-1:0]  row,
    input logic [11:0]             col,
    input logic [2:0]              rw,
    input logic [1:0]              cw,
    input logic                    order
  );
    logic [AW-1:0]          a;
    logic [C_ROW_WIDTH-1:0] rmask;
    int                     cb;
    int                     rb;
    int                     top;
    cb    = col_bits(cw);
    rb    = row_bits(rw);
    top   = OFFSET_BITS + cb + rb;
    rmask = {C_ROW_WIDTH{1'b1}} >> (C_ROW_WIDTH - rb);
    a  = {{(AW-12){1'b0}}, col & col_mask(cw)} << OFFSET_BITS;
    a |= {{(AW-C_ROW_WIDTH){1'b0}}, row & rmask} << (OFFSET_BITS + cb);
    if (!order) begin
      a |= {{(AW-C_BANK_WIDTH){1'b0}}, bank} << top;
      a |= {{(AW-C_CS_WIDTH){1'b0}}, rank} << (top + C_BANK_WIDTH);
    end else begin
      a |= {{(AW-C_CS_WIDTH){1'b0}}, rank} << top;
      a |= {{(AW-C_BANK_WIDTH){1'b0}}, bank} << (top + C_CS_WIDTH);
    end
    pack_addr = a;
  endfunction

  logic                    state_r;
  logic [C_CS_WIDTH-1:0]   rank_r;
  logic [C_BANK_WIDTH-1:0] bank_r;
  logic [C_ROW_WIDTH-1:0]  row_r;
  logic [11:0]             col_r;
  logic [C_LEN_WIDTH-1:0]  cnt_r;
  logic [2:0]              rw_r;
  logic [1:0]              cw_r;
  logic                    bor_r;
  logic [AW-1:0]           addr_r;
  logic                    last_r;

  logic          accept_s;
  logic          beat_s;
  logic [11:0]   col_next_s;
  logic [AW-1:0] first_addr_s;
  logic [AW-1:0] next_addr_s;

  assign out_valid = (state_r == BURST);
  assign out_addr  = addr_r;
  assign out_last  = last_r;
  assign beat_s    = out_valid & out_ready;
  assign in_ready  = (state_r == IDLE) | (beat_s & last_r);
  assign accept_s  = in_valid & in_ready;

  // Next-beat column (wrapping within the row) and the addresses to register.
  always_comb begin
    col_next_s   = (col_r + 12'd1) & col_mask(cw_r);
    first_addr_s = pack_addr(in_rank, in_bank, in_row, in_column, r_width, c_width, bor);
    next_addr_s  = pack_addr(rank_r, bank_r, row_r, col_next_s, rw_r, cw_r, bor_r);
  end

  // Command latch, beat sequencing and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rank_r  <= '0;
      bank_r  <= '0;
      row_r   <= '0;
      col_r   <= 12'd0;
      cnt_r   <= '0;
      rw_r    <= 3'd0;
      cw_r    <= 2'd0;
      bor_r   <= 1'b0;
      addr_r  <= '0;
      last_r  <= 1'b0;
    end else if (accept_s) begin
      state_r <= BURST;
      rank_r  <= in_rank;
      bank_r  <= in_bank;
      row_r   <= in_row;
      col_r   <= in_column & col_mask(c_width);
      cnt_r   <= in_len;
      rw_r    <= r_width;
      cw_r    <= c_width;
      bor_r   <= bor;
      addr_r  <= first_addr_s;
      last_r  <= (in_len == '0);
    end else if (beat_s) begin
      if (last_r) begin
        state_r <= IDLE;
        last_r  <= 1'b0;
      end else begin
        col_r  <= col_next_s;
        cnt_r  <= cnt_r - LEN_ONE;
        addr_r <= next_addr_s;
        last_r <= (cnt_r == LEN_ONE);
      end
    end
  end

endmodule

// File: tb/tb_address_demapper.sv
// Directed bench for address_demapper with hand-computed beat addresses.
module tb_address_demapper;

  localparam logic [2:0] R11 = 3'd0;
  localparam logic [2:0] R13 = 3'd2;
  localparam logic [2:0] R15 = 3'd4;
  localparam logic [1:0] C9  = 2'd0;
  localparam logic [1:0] C10 = 2'd1;
  localparam logic [1:0] C11 = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  r_width;
  logic [1:0]  c_width;
  logic        bor;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_rank;
  logic [2:0]  in_bank;
  logic [15:0] in_row;
  logic [11:0] in_column;
  logic [7:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_addr;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_a [4];
  logic        pat   [10];

  address_demapper dut (
    .clk(clk), .rst_n(rst_n), .r_width(r_width), .c_width(c_width), .bor(bor),
    .in_valid(in_valid), .in_ready(in_ready), .in_rank(in_rank), .in_bank(in_bank),
    .in_row(in_row), .in_column(in_column), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [0:0] rk, input logic [2:0] bk, input logic [15:0] rw,
                     input logic [11:0] cl, input logic [7:0] ln,
                     input logic [2:0] rwid, input logic [1:0] cwid, input logic order);
    in_rank   = rk;
    in_bank   = bk;
    in_row    = rw;
    in_column = cl;
    in_len    = ln;
    r_width   = rwid;
    c_width   = cwid;
    bor       = order;
    in_valid  = 1'b1;
  endtask

  initial begin
    int k;
    exp_a[0] = 64'hD048FFF0;
    exp_a[1] = 64'hD048FFF8;
    exp_a[2] = 64'hD048C000;
    exp_a[3] = 64'hD048C008;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rank = 1'b0; in_bank = 3'd0; in_row = 16'd0; in_column = 12'd0; in_len = 8'd0;
    r_width = R11; c_width = C9; bor = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Basic four-beat burst with column wrap
    cmd(1'b1, 3'd5, 16'h0123, 12'h7FE, 8'd3, R13, C10, 1'b0);
    tick(); in_valid = 1'b0;
    chk("b1_valid", 64'(out_valid), 64'd1);
    chk("b1_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("b1_addr", 64'(out_addr), exp_a[i]);
      chk("b1_last", 64'(out_last), (i == 3) ? 64'd1 : 64'd0);
    end
    chk("b1_ready_last", 64'(in_ready), 64'd1);
    tick();
    chk("b1_idle", 64'(out_valid), 64'd0);

    // Single beat, bor=1, upper column/row bits ignored
    cmd(1'b1, 3'd2, 16'hFABC, 12'hFFF, 8'd0, R11, C9, 1'b1);
    tick(); in_valid = 1'b0;
    chk("s_valid", 64'(out_valid), 64'd1);
    chk("s_addr", 64'(out_addr), 64'h0B579FF8);
    chk("s_last", 64'(out_last), 64'd1);
    chk("s_ready", 64'(in_ready), 64'd1);
    tick();
    chk("s_idle", 64'(out_valid), 64'd0);

    // Back-pressure: addresses hold across stalls
    cmd(1'b1, 3'd5, 16'h0123, 12'h7FE, 8'd3, R13, C10, 1'b0);
    tick(); in_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      out_ready = pat[i];
      #1;
      chk("st_addr", 64'(out_addr), exp_a[k]);
      chk("st_last", 64'(out_last), (k == 3) ? 64'd1 : 64'd0);
      chk("st_ready", 64'(in_ready), (pat[i] && k == 3) ? 64'd1 : 64'd0);
      tick();
      if (pat[i]) k++;
    end
    out_ready = 1'b1;
    chk("st_idle", 64'(out_valid), 64'd0);

    // Back-to-back commands with no bubble
    cmd(1'b1, 3'd5, 16'h0123, 12'h7FE, 8'd1, R13, C10, 1'b0);
    tick(); in_valid = 1'b0;
    chk("bb_a0", 64'(out_addr), 64'hD048FFF0);
    tick();
    chk("bb_a1", 64'(out_addr), 64'hD048FFF8);
    chk("bb_a1_last", 64'(out_last), 64'd1);
    cmd(1'b1, 3'd2, 16'h0ABC, 12'h3FF, 8'd0, R11, C9, 1'b1);
    #1;
    chk("bb_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    chk("bb_b_valid", 64'(out_valid), 64'd1);
    chk("bb_b_addr", 64'(out_addr), 64'h0B579FF8);
    chk("bb_b_last", 64'(out_last), 64'd1);
    tick();
    chk("bb_idle", 64'(out_valid), 64'd0);

    // Geometry inputs change mid-burst
    cmd(1'b1, 3'd5, 16'h0123, 12'h7FE, 8'd3, R13, C10, 1'b0);
    tick(); in_valid = 1'b0;
    r_width = R15; c_width = C11; bor = 1'b1; in_column = 12'h123;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("g_addr", 64'(out_addr), exp_a[i]);
    end
    chk("g_last", 64'(out_last), 64'd1);
    tick();
    chk("g_idle", 64'(out_valid), 64'd0);

    // Reset in the middle of a len=7 burst (RB=16, CB=12)
    cmd(1'b0, 3'd0, 16'h0001, 12'h010, 8'd7, R15, C11, 1'b0);
    tick(); in_valid = 1'b0;
    chk("r_b0", 64'(out_addr), 64'h8080);
    tick();
    chk("r_b1", 64'(out_addr), 64'h8088);
    rst_n = 1'b0;
    #1;
    chk("r_valid", 64'(out_valid), 64'd0);
    chk("r_addr", 64'(out_addr), 64'd0);
    chk("r_last", 64'(out_last), 64'd0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("r_ready", 64'(in_ready), 64'd1);
    chk("r_novalid0", 64'(out_valid), 64'd0);
    tick();
    chk("r_novalid1", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
